// File: rtl/shift_iter.sv
// Iterative 32-bit shifter: SRL/SLL/SRA, up to STEP bits per cycle, valid/ready in and out.
// Optional SHIFT_ITER_ROTATE_EN makes op 11 a rotate-right; otherwise op 11 behaves as SRL.
module shift_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, shifted;
  logic [4:0]       rem, rem_nxt, n;
  logic [1:0]       op_q, op_q_nxt;
  logic             unused_b;

  assign unused_b  = ^b[WIDTH-1:5];
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res       = (state == DONE) ? acc : '0;

  // n never exceeds rem, so rem cannot underflow and n > 0 whenever in SHIFT
  assign n = (rem < STEP_W) ? rem : STEP_W;

  always_comb begin
    shifted = acc >> n;
    case (op_q)
      2'b01: shifted = acc << n;
      // acc[31] is the sign latched at acceptance and is never altered by SRA
      2'b10: shifted = $signed(acc) >>> n;
`ifdef SHIFT_ITER_ROTATE_EN
      2'b11: shifted = (acc >> n) | (acc << (6'd32 - {1'b0, n}));
`else
      2'b11: shifted = acc >> n;
`endif
      default: shifted = acc >> n;
    endcase
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    op_q_nxt  = op_q;
    case (state)
      IDLE: if (in_valid) begin
        acc_nxt   = a;
        rem_nxt   = b[4:0];
        op_q_nxt  = op;
        state_nxt = (b[4:0] == 5'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        acc_nxt = shifted;
        rem_nxt = rem - n;
        if (rem == n) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      op_q  <= 2'b00;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      op_q  <= op_q_nxt;
    end
  end

endmodule

// File: tb/tb_shift_iter.sv
// Directed table-driven bench for shift_iter plus backpressure and mid-op reset sequences.
module tb_shift_iter;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  shift_iter #(.WIDTH(32), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request with out_ready held high; checks latency, result and in_ready return.
  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic [1:0] vop, input logic [31:0] exp);
    int cyc;
    int k;
    k = (int'(vb[4:0]) + STEP - 1) / STEP;
    @(negedge clk);
    check({name, " in_ready before"}, 32'(in_ready), 32'd1);
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0000_001F; op = 2'b01;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(k));
    check({name, " res"}, res, exp);
    @(posedge clk);
    #1;
    check({name, " in_ready after"}, 32'(in_ready), 32'd1);
    check({name, " out_valid after"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    vecs.push_back('{32'd11242412, 32'd2,  2'b00, 32'd2810603});
    vecs.push_back('{32'd32143513, 32'd7,  2'b00, 32'd251121});
    vecs.push_back('{32'd93152513, 32'd32, 2'b00, 32'd93152513});
    vecs.push_back('{32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF});
    vecs.push_back('{32'd1,         32'd5,  2'b01, 32'd32});
    vecs.push_back('{32'hF000_0000, 32'd4,  2'b10, 32'hFF00_0000});
    vecs.push_back('{32'h7FFF_FFFF, 32'd31, 2'b10, 32'h0000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'd31, 2'b01, 32'h8000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'd31, 2'b00, 32'h0000_0001});
    vecs.push_back('{32'h0000_0080, 32'h23, 2'b00, 32'h0000_0010});
`ifdef SHIFT_ITER_ROTATE_EN
    vecs.push_back('{32'h0000_0001, 32'd4,  2'b11, 32'h1000_0000});
    vecs.push_back('{32'h0000_00F1, 32'd9,  2'b11, 32'h7880_0000});
`else
    vecs.push_back('{32'h0000_0001, 32'd4,  2'b11, 32'h0000_0000});
    vecs.push_back('{32'h0000_00F1, 32'd9,  2'b11, 32'h0000_0000});
`endif

    // reset state
    #12;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst res", res, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

    // backpressure: result held for 5 cycles with out_ready low
    @(negedge clk);
    a = 32'd1513242; b = 32'd5; op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp latency", 32'(cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp res %0d", i), res, 32'd47288);
      check($sformatf("bp out_valid %0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp in_ready %0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp busy %0d", i), 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp out_valid drop", 32'(out_valid), 32'd0);
    check("bp in_ready back", 32'(in_ready), 32'd1);

    // reset during the second SHIFT cycle
    @(negedge clk);
    a = 32'd73412343; b = 32'd9; op = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid busy pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid out_valid", 32'(out_valid), 32'd0);
    check("mid res", res, 32'd0);
    check("mid busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // no stale result may appear after release
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    check("mid no result", 32'(cyc), 32'd0);
    run_op("post rst", 32'd72345233, 32'd7, 2'b00, 32'd565197);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_iter.md
Name: shift_iter

Overview:
- Multi-cycle sequential shift unit for the 32-bit ALU library.
- Sits directly upstream of the ALU result mux. It replaces the single-cycle srl path when a smaller, iterative shifter is wanted.
- Accepts an operand, a shift amount and an opcode over a valid/ready handshake. Shifts STEP bits per cycle and presents the result over an output valid/ready handshake.
- The arithmetic result for SRL is bit-identical to the combinational srl module.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the shift amount is 5 bits.
- STEP, 4, maximum bits shifted per cycle. Must be a power of two, 1..16.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- a  in  32  operand to shift
- b  in  32  shift amount. Only b[4:0] is used; b[31:5] is ignored, matching srl semantics.
- op  in  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 see Optional Feature
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- res  out  32  shifted result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, rem=0, op_q=00, res=0, out_valid=0, busy=0.
- in_ready = (state==IDLE) && !rst. It is combinational from the registered state only. It never depends on in_valid.
- States:
  - IDLE: in_ready=1. When in_valid && in_ready at an edge: acc<=a, rem<=b[4:0], op_q<=op. Next state is DONE if b[4:0]==0, otherwise SHIFT.
  - SHIFT: each cycle n=min(STEP, rem); acc<=acc shifted by n per op_q; rem<=rem-n. Next state is DONE when rem-n==0, otherwise stay in SHIFT.
  - DONE: out_valid=1, res=acc. Hold until out_ready, then go to IDLE. res and out_valid stay stable while out_ready=0.
- Shift rules:
  - SRL fills with 0.
  - SLL fills with 0.
  - SRA fills with acc[31] as latched at acceptance. The sign bit does not change during SRA, so the fill value is stable.
- Latency: k = ceil(b[4:0]/STEP) SHIFT cycles.
  - out_valid rises after acceptance edge + k + 1 edges. With b[4:0]==0, it is high the cycle after acceptance.
  - Worst case for STEP=4 is shamt 31: 8 shift cycles.
- No overlap: in_ready=0 during SHIFT and DONE. Minimum initiation interval is k+2 cycles when out_ready is held high.
- The result handshake completes on the edge where out_valid && out_ready. in_ready rises the following cycle.
- Changes on a, b or op after acceptance have no effect.
- Reset mid-operation (any state): the unit returns to IDLE immediately and asynchronously. out_valid drops, res=0, the in-flight request is discarded, and no result is produced.
- rem is 5 bits and never underflows, because n ≤ rem by construction.

Optional Feature:
- Macro: SHIFT_ITER_ROTATE_EN.
- Defined: op 11 = rotate right by b[4:0]. Bits leaving acc[0] re-enter at acc[31], STEP bits per cycle, with the same latency as SRL.
- Not defined: op 11 is executed exactly as SRL (00). No error indication is given.
- Ports and handshake timing are identical in both builds.

Test Plan:
- SRL, a=11242412, b=2, op=00, out_ready=1: res=2810603. out_valid high 2 cycles after acceptance (k=1). in_ready returns 1 the cycle after handshake.
- SRL, a=32143513, b=7: res=251121, k=2. Then b=32 (b[4:0]=0) with a=93152513: res=93152513, out_valid the cycle after acceptance.
- SRA, a=0x80000000, b=31, op=10: res=0xFFFFFFFF after 8 shift cycles. SLL, a=1, b=5, op=01: res=32.
- Backpressure: a=1513242, b=5, SRL, out_ready=0 for 5 cycles. res=47288 held stable with out_valid=1, in_ready=0 and busy=1 throughout. The result is accepted on the first edge with out_ready=1.
- Reset mid-op: start SRL a=73412343, b=9. Assert rst during the 2nd SHIFT cycle. out_valid=0 and res=0 immediately. After release, a=72345233, b=7 gives res=565197.
- op=11, a=0x00000001, b=4: res=0x10000000 with SHIFT_ITER_ROTATE_EN defined, 0x00000000 without.
